// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative divider: widths, FSM state codes and
// the divide-by-zero quotient constant.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_ITER  = MDU_WIDTH;

    localparam logic [MDU_WIDTH-1:0] DIV_ZERO_QUO = '1;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIX  = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; serves as abs() on operands and as the
// sign restore on quotient/remainder.
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mdu_div.sv
// Radix-2 restoring DIV/DIVU unit, one quotient bit per cycle.
// MDU_DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module mdu_div
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Sign,
    input  logic             cancel,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             dvd_neg_q, dvd_neg_d;
    logic             dvs_neg_q, dvs_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix;
    logic [WIDTH+1:0] prem_sh, trial;
    logic             trial_neg, accept;

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvd (.val_i(in1), .neg_i(Sign & in1[WIDTH-1]), .val_o(dvd_abs));
    div_sign_fix #(.WIDTH(WIDTH)) u_abs_dvs (.val_i(in2), .neg_i(Sign & in2[WIDTH-1]), .val_o(dvs_abs));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (.val_i(dvd_q), .neg_i(sign_q & (dvd_neg_q ^ dvs_neg_q)), .val_o(quo_fix));
    div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (.val_i(prem_q[WIDTH-1:0]), .neg_i(sign_q & dvd_neg_q), .val_o(rem_fix));

    assign accept    = start & ~cancel & ((state_q == IDLE) | (state_q == DONE));
    // prem never exceeds the divisor, so WIDTH+2 bits leave a clean borrow bit.
    assign prem_sh   = {prem_q, dvd_q[WIDTH-1]};
    assign trial     = prem_sh - {2'b00, dvs_q};
    assign trial_neg = trial[WIDTH+1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        dz_d      = dz_q;
        in1_d     = in1_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    sign_d    = Sign;
                    dvd_neg_d = Sign & in1[WIDTH-1];
                    dvs_neg_d = Sign & in2[WIDTH-1];
                    dz_d      = (in2 == '0);
                    in1_d     = in1;
                    dvd_d     = dvd_abs;
                    dvs_d     = dvs_abs;
                    prem_d    = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
`ifdef MDU_DIV_ZERO_FAST_EN
                    if (in2 == '0) state_d = FIX;
`endif
                end
            end
            CALC: begin
                prem_d = trial_neg ? prem_sh[WIDTH:0] : trial[WIDTH:0];
                dvd_d  = {dvd_q[WIDTH-2:0], ~trial_neg};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                state_d = DONE;
                quo_d   = dz_q ? WIDTH'(DIV_ZERO_QUO) : quo_fix;
                rem_d   = dz_q ? in1_q : rem_fix;
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over everything, including the FIX result write.
        if (cancel) begin
            state_d = IDLE;
            quo_d   = quo_q;
            rem_d   = rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            in1_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            dz_q      <= dz_d;
            in1_q     <= in1_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
        end
    end

    assign busy = (state_q == CALC) | (state_q == FIX);
    assign done = (state_q == DONE);
    assign quo  = quo_q;
    assign rem  = rem_q;

endmodule

// File: tb/tb_mdu_div.sv
// Bench for mdu_div: cycle-level behavioural model checked every cycle, plus
// directed cases with literal expectations and a randomized sweep.
module tb_mdu_div;

    localparam int W = 32;
`ifdef MDU_DIV_ZERO_FAST_EN
    localparam int DZ_BUSY = 1;
`else
    localparam int DZ_BUSY = 33;
`endif

    logic         clk = 1'b0, reset = 1'b1, start = 1'b0, Sign = 1'b0, cancel = 1'b0;
    logic [W-1:0] in1 = '0, in2 = '0;
    logic         busy, done;
    logic [W-1:0] quo, rem;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_div dut (
        .clk(clk), .reset(reset), .start(start), .Sign(Sign), .cancel(cancel),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .quo(quo), .rem(rem)
    );

    // Reference arithmetic: truncating division, remainder follows dividend.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: cycles of busy remaining, then a one-cycle done with new results.
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_quo = '0, m_rem = '0, p_quo = '0, p_rem = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_done = 1'b0; m_quo = '0; m_rem = '0;
        end else if (cancel) begin
            m_left = 0; m_done = 1'b0;
        end else if (m_left == 0) begin
            m_done = 1'b0;
            if (start) begin
                ref_div(in1, in2, Sign, p_quo, p_rem);
                m_left = (in2 == '0) ? DZ_BUSY : 33;
            end
        end else begin
            m_left--;
            m_done = 1'b0;
            if (m_left == 0) begin
                m_done = 1'b1; m_quo = p_quo; m_rem = p_rem;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", W'(busy), W'(m_left > 0));
        chk("done", W'(done), W'(m_done));
        chk("quo",  quo, m_quo);
        chk("rem",  rem, m_rem);
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in1 = a; in2 = b; Sign = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n0 = cycle index (relative to the accepting edge) of the current negedge.
    task automatic wait_done(input string nm, input int n0, input int lat,
                             input logic [W-1:0] eq, input logic [W-1:0] er);
        int n = n0;
        while (!done && n < lat + 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " latency"}, W'(n), W'(lat));
        chk({nm, " quo"}, quo, eq);
        chk({nm, " rem"}, rem, er);
    endtask

    initial begin
        logic [W-1:0] q, r, a, b, eq, er;
        logic         s;
        int           nd, k, sel, lat;

        ref_div(32'd100, 32'd7, 1'b0, q, r);
        chk("pin 100/7 q", q, 32'd14); chk("pin 100/7 r", r, 32'd2);
        ref_div(32'hFFFFFFF9, 32'd2, 1'b1, q, r);
        chk("pin -7/2 q", q, 32'hFFFFFFFD); chk("pin -7/2 r", r, 32'hFFFFFFFF);
        ref_div(32'd7, 32'hFFFFFFFE, 1'b1, q, r);
        chk("pin 7/-2 q", q, 32'hFFFFFFFD); chk("pin 7/-2 r", r, 32'd1);
        ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1, q, r);
        chk("pin ovf q", q, 32'h80000000); chk("pin ovf r", r, 32'd0);

        repeat (3) @(negedge clk);
        chk("reset busy", W'(busy), '0); chk("reset done", W'(done), '0);
        chk("reset quo", quo, '0);       chk("reset rem", rem, '0);
        reset = 1'b0;
        @(negedge clk);

        launch(32'd100, 32'd7, 1'b0);             wait_done("u100/7", 1, 34, 32'd14, 32'd2);
        @(negedge clk); launch(32'hFFFFFFF9, 32'd2, 1'b1); wait_done("s-7/2", 1, 34, 32'hFFFFFFFD, 32'hFFFFFFFF);
        @(negedge clk); launch(32'd7, 32'hFFFFFFFE, 1'b1); wait_done("s7/-2", 1, 34, 32'hFFFFFFFD, 32'd1);
        @(negedge clk); launch(32'h80000000, 32'hFFFFFFFF, 1'b1); wait_done("ovf", 1, 34, 32'h80000000, 32'd0);
        @(negedge clk); launch(32'hFFFFFFFF, 32'd1, 1'b0); wait_done("umax/1", 1, 34, 32'hFFFFFFFF, 32'd0);
        @(negedge clk); launch(32'h12345678, 32'd0, 1'b0); wait_done("dz u", 1, DZ_BUSY + 1, 32'hFFFFFFFF, 32'h12345678);
        @(negedge clk); launch(32'h80000000, 32'd0, 1'b1); wait_done("dz s", 1, DZ_BUSY + 1, 32'hFFFFFFFF, 32'h80000000);

        // back-to-back: second start issued in the done cycle
        @(negedge clk); launch(32'd1000, 32'd3, 1'b0); wait_done("b2b first", 1, 34, 32'd333, 32'd1);
        launch(32'd50, 32'd5, 1'b0);               wait_done("b2b second", 1, 34, 32'd10, 32'd0);

        // start while busy must be dropped
        @(negedge clk); launch(32'd200, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        in1 = 32'd1; in2 = 32'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("ignored start", 6, 34, 32'd22, 32'd2);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done) nd++; end
        chk("ignored start extra done", W'(nd), '0);

        // cancel at T+10
        launch(32'd999, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk); cancel = 1'b0;
        chk("cancel busy", W'(busy), '0);
        nd = 0;
        repeat (40) begin @(negedge clk); if (done) nd++; end
        chk("cancel done count", W'(nd), '0);
        chk("cancel quo kept", quo, 32'd22); chk("cancel rem kept", rem, 32'd2);

        // reset mid-CALC
        launch(32'd12345, 32'd6, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("midreset busy", W'(busy), '0); chk("midreset done", W'(done), '0);
        chk("midreset quo", quo, '0);       chk("midreset rem", rem, '0);
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            else if (sel == 1) b = $urandom_range(1, 15);
            else if (sel == 2) begin a = 32'h80000000; b = '1; end
            else if (sel == 3) b = '1;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ref_div(a, b, s, eq, er);
            lat = (b == '0) ? DZ_BUSY + 1 : 34;
            launch(a, b, s);
            if (b != '0 && $urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, 20);
                repeat (k) @(negedge clk);
                in1 = $urandom; in2 = $urandom; start = 1'b1;
                @(negedge clk); start = 1'b0;
                wait_done("rand spurious", k + 2, lat, eq, er);
            end else begin
                wait_done("rand", 1, lat, eq, er);
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
